// File: rtl/lsb_mem_unit.sv
// Byte-serial load/store unit: splits byte/half/word accesses into single-byte memory port
// transactions, extends load data, and back-pressures stores into the I/O region.
module lsb_mem_unit #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush_in,
    input  logic        io_buffer_full,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        lsb_en,
    output logic        lsb_wr,
    output logic [31:0] lsb_addr,
    output logic [7:0]  lsb_data,
    input  logic [7:0]  lsb_read_data
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q;
    logic        alive_q;
    logic        signed_q;
    logic [1:0]  last_q;
    logic [1:0]  k_q;
    logic [1:0]  cap_q;
    logic        cap_vld_q;
    logic        en_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [7:0]  data_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;

    logic        stall;
    logic [1:0]  k_next;
    logic [1:0]  req_last;
    logic [31:0] merged;
    logic [31:0] ext;

    // I/O back-pressure gates the port combinationally so a blocked byte is never issued.
    assign stall     = (state_q == StWrite) && (addr_q >= IO_BASE) && io_buffer_full;
    assign lsb_en    = en_q & ~stall;
    assign lsb_wr    = wr_q & lsb_en;
    assign lsb_addr  = addr_q;
    assign lsb_data  = data_q;
    assign req_ready = alive_q && (state_q == StIdle) && !flush_in;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign k_next     = k_q + 2'd1;
    assign req_last   = (req_size == 2'd0) ? 2'd0 : (req_size == 2'd1) ? 2'd1 : 2'd3;

    always_comb begin
        merged = rbuf_q;
        merged[{cap_q, 3'b000} +: 8] = lsb_read_data;
        case (last_q)
            2'd0:    ext = {{24{signed_q & merged[7]}}, merged[7:0]};
            2'd1:    ext = {{16{signed_q & merged[15]}}, merged[15:0]};
            default: ext = merged;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            alive_q      <= 1'b0;
            signed_q     <= 1'b0;
            last_q       <= 2'd0;
            k_q          <= 2'd0;
            cap_q        <= 2'd0;
            cap_vld_q    <= 1'b0;
            en_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            data_q       <= 8'd0;
            wdata_q      <= 32'd0;
            rbuf_q       <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            alive_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        signed_q  <= req_signed;
                        last_q    <= req_last;
                        wdata_q   <= req_wdata;
                        addr_q    <= req_addr;
                        data_q    <= req_wdata[7:0];
                        k_q       <= 2'd0;
                        cap_vld_q <= 1'b0;
                        rbuf_q    <= 32'd0;
                        en_q      <= 1'b1;
                        wr_q      <= req_wr;
                        state_q   <= req_wr ? StWrite : StRead;
                    end
                end
                StRead: begin
                    if (flush_in) begin
                        state_q   <= StIdle;
                        en_q      <= 1'b0;
                        cap_vld_q <= 1'b0;
                        rbuf_q    <= 32'd0;
                    end else begin
                        // Capture trails issue by one cycle; cap_q names the lane now on the bus.
                        if (cap_vld_q) begin
                            rbuf_q <= merged;
                            if (cap_q == last_q) begin
                                state_q      <= StResp;
                                resp_valid_q <= 1'b1;
                                resp_data_q  <= ext;
                            end
                        end
                        cap_vld_q <= en_q;
                        cap_q     <= k_q;
                        if (en_q) begin
                            if (k_q == last_q) begin
                                en_q <= 1'b0;
                            end else begin
                                k_q    <= k_next;
                                addr_q <= addr_q + 32'd1;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (!stall) begin
                        if (k_q == last_q) begin
                            en_q         <= 1'b0;
                            wr_q         <= 1'b0;
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= 32'd0;
                        end else begin
                            k_q    <= k_next;
                            addr_q <= addr_q + 32'd1;
                            data_q <= wdata_q[{k_next, 3'b000} +: 8];
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsb_mem_unit.sv
// Scoreboard bench for lsb_mem_unit: a byte-array reference model predicts bus traffic and
// responses; independent monitors compare the DUT memory port and response channel.
module tb_lsb_mem_unit;

    localparam logic [31:0] IoBase = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        flush_in = 1'b0;
    logic        io_full = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        lsb_en;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [7:0]  lsb_data;
    logic [7:0]  rd_q = 8'd0;

    lsb_mem_unit #(.IO_BASE(IoBase)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .flush_in      (flush_in),
        .io_buffer_full(io_full),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .lsb_en        (lsb_en),
        .lsb_wr        (lsb_wr),
        .lsb_addr      (lsb_addr),
        .lsb_data      (lsb_data),
        .lsb_read_data (rd_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        logic        wr;
    } bus_t;

    resp_t      resp_q[$];
    bus_t       bus_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] dev_mem[logic [31:0]];
    logic [7:0] ref_mem[logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        dev_mem[a] = b;
        ref_mem[a] = b;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory device plus bus-traffic monitor.
    always @(posedge clk) begin
        if (rst_n && lsb_en) begin
            if (bus_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bus_spurious: got addr %h wr %b expected no access", lsb_addr, lsb_wr);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                check("bus_addr", lsb_addr, e.addr);
                check("bus_wr", {31'd0, lsb_wr}, {31'd0, e.wr});
                if (e.wr) check("bus_wdata", {24'd0, lsb_data}, {24'd0, e.data});
            end
            if (lsb_wr) dev_mem[lsb_addr] = lsb_data;
            else rd_q <= dev_rd(lsb_addr);
        end
    end

    // Response monitor.
    always @(posedge clk) begin
        #1;
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_spurious: got data %h expected no response", resp_data);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one access with the unit idle; flush_at selects the post-issue cycle index that
    // carries flush (loads), stall the number of io_buffer_full cycles (I/O stores).
    task automatic do_req(input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int flush_at, input int stall);
        int          n;
        int          p;
        int          issued;
        bit          io_reg;
        bit          done;
        longint      v;
        logic [31:0] a;
        n      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        io_reg = (addr >= IoBase);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        flush_in   = 1'b0;
        io_full    = 1'b0;
        #1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        p = cyc + 1;
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                ref_mem[a] = wdata[8*k +: 8];
                bus_q.push_back('{addr: a, data: wdata[8*k +: 8], wr: 1'b1});
            end
            resp_q.push_back('{data: 32'd0, cyc: p + n + stall});
        end else begin
            issued = (flush_at < 0 || flush_at > n - 1) ? n : flush_at + 1;
            v = 0;
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                if (k < issued) bus_q.push_back('{addr: a, data: 8'd0, wr: 1'b0});
                v = v + (longint'(ref_rd(a)) << (8 * k));
            end
            if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            if (flush_at < 0 || flush_at > n) resp_q.push_back('{data: 32'(v), cyc: p + n + 1});
        end
        @(posedge clk);
        done = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush_in  = 1'b0;
            io_full   = 1'b0;
            #1;
            if (req_ready) begin
                done = 1'b1;
            end else if (wr) begin
                flush_in = ($urandom_range(0, 3) == 0);
                io_full  = io_reg ? (c <= stall) : 1'($urandom_range(0, 1));
            end else begin
                flush_in = (c == flush_at + 1);
                io_full  = 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: got busy after 60 cycles expected idle");
        end
    endtask

    initial begin
        int          rn;
        logic [1:0]  rsize;
        logic [31:0] raddr;
        bit          rwr;
        // Reset state, asserted from time zero.
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_lsb_en", {31'd0, lsb_en}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_release", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Word load of a known pattern.
        poke(32'h100, 8'h78);
        poke(32'h101, 8'h56);
        poke(32'h102, 8'h34);
        poke(32'h103, 8'h12);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, -1, 0);

        // Sign/zero extension.
        poke(32'h110, 8'h80);
        do_req(1'b0, 2'd0, 1'b1, 32'h110, 32'd0, -1, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h110, 32'd0, -1, 0);
        poke(32'h120, 8'h01);
        poke(32'h121, 8'h80);
        do_req(1'b0, 2'd1, 1'b1, 32'h120, 32'd0, -1, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h120, 32'd0, -1, 0);

        // Misaligned word store then read-back.
        do_req(1'b1, 2'd2, 1'b0, 32'h201, 32'hDEADBEEF, -1, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h201, 32'd0, -1, 0);

        // I/O store held off for three cycles.
        do_req(1'b1, 2'd0, 1'b0, IoBase, 32'h41, -1, 3);

        // Flushed word load followed by a fresh request.
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, -1, 0);

        // Flush and request together in idle: no acceptance.
        req_valid = 1'b1;
        flush_in  = 1'b1;
        req_addr  = 32'h100;
        req_wr    = 1'b0;
        #1;
        check("ready_under_flush", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        flush_in  = 1'b0;
        #1;
        check("ready_after_flush", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);

        // Address wrap and size 3 as word.
        do_req(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'd0, -1, 0);
        do_req(1'b1, 2'd3, 1'b0, 32'h180, 32'h0BAD_F00D, -1, 0);
        do_req(1'b0, 2'd3, 1'b0, 32'h180, 32'd0, -1, 0);

        // Reset two bytes into a word store.
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h300;
        req_wdata = 32'hCAFE_F00D;
        #1;
        check("ready_pre_rst_store", {31'd0, req_ready}, 32'd1);
        ref_mem[32'h300] = 8'h0D;
        ref_mem[32'h301] = 8'hF0;
        bus_q.push_back('{addr: 32'h300, data: 8'h0D, wr: 1'b1});
        bus_q.push_back('{addr: 32'h301, data: 8'hF0, wr: 1'b1});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_lsb_en", {31'd0, lsb_en}, 32'd0);
        check("arst_lsb_wr", {31'd0, lsb_wr}, 32'd0);
        check("arst_lsb_addr", lsb_addr, 32'd0);
        check("arst_lsb_data", {24'd0, lsb_data}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd0);
        check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_ready_pre_edge", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_ready_post_edge", {31'd0, req_ready}, 32'd1);
        check("arst_byte0", {24'd0, dev_rd(32'h300)}, 32'h0D);
        check("arst_byte1", {24'd0, dev_rd(32'h301)}, 32'hF0);
        check("arst_byte2_untouched", {24'd0, dev_rd(32'h302)}, {24'd0, init_byte(32'h302)});
        @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            rsize = 2'($urandom_range(0, 3));
            rn    = (rsize == 2'd0) ? 1 : (rsize == 2'd1) ? 2 : 4;
            rwr   = 1'($urandom_range(0, 1));
            raddr = ($urandom_range(0, 3) == 0) ? IoBase + 32'($urandom_range(0, 15))
                                                : 32'h100 + 32'($urandom_range(0, 255));
            do_req(rwr, rsize, 1'($urandom_range(0, 1)), raddr, $urandom,
                   (!rwr && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn + 1)) : -1,
                   (rwr && raddr >= IoBase) ? int'($urandom_range(0, 3)) : 0);
        end

        repeat (5) @(negedge clk);
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsb_mem_unit.md
LSB_MEM_UNIT -- requirements
Module: lsb_mem_unit

Interface
REQ-001 Parameter: IO_BASE, 32'h00030000, lowest address of memory-mapped I/O space.
REQ-002 Port: clk_in  input  1  clock; all state changes on rising edge.
REQ-003 Port: rst_in  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  load/store request present.
REQ-005 Port: req_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: req_wr  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-008 Port: req_signed  input  1  loads only; 1 = sign-extend, 0 = zero-extend.
REQ-009 Port: req_addr  input  32  byte address of the access.
REQ-010 Port: req_wdata  input  32  store data, little-endian, low bytes used.
REQ-011 Port: flush_in  input  1  pipeline flush; aborts loads.
REQ-012 Port: io_buffer_full  input  1  I/O sink cannot take a byte.
REQ-013 Port: resp_valid  output  1  one-cycle pulse, access complete.
REQ-014 Port: resp_data  output  32  extended load data; 0 for stores.
REQ-015 Port: lsb_en  output  1  memory port request to mem_controller.
REQ-016 Port: lsb_wr  output  1  1 = byte write.
REQ-017 Port: lsb_addr  output  32  byte address on memory port.
REQ-018 Port: lsb_data  output  8  byte to write.
REQ-019 Port: lsb_read_data  input  8  byte read, valid the cycle after its address.

Function
REQ-020 States: IDLE, READ, WRITE, RESP; req_ready is 1 only in IDLE with flush_in=0.
REQ-021 Accept on req_valid && req_ready; latch wr/size/signed/addr/wdata; N = 1, 2 or 4 bytes; next state is READ or WRITE.
REQ-022 READ: in issue cycles k=0..N-1, drive lsb_en=1, lsb_wr=0, lsb_addr=addr+k (mod 2^32), with no gaps.
REQ-023 READ: capture lsb_read_data one cycle after each issue into byte lane k.
REQ-024 READ: after the last capture, load resp_data (extended per size/signed), pulse resp_valid for one cycle (RESP), then return to IDLE.
REQ-025 Load latency: byte resp_valid in the 3rd cycle after acceptance; half in the 4th; word in the 6th.
REQ-026 WRITE: in cycles k=0..N-1, drive lsb_en=1, lsb_wr=1, lsb_addr=addr+k, lsb_data=wdata[8k+7:8k].
REQ-027 WRITE: resp_valid pulses in the cycle after the last byte; word store responds in the 5th cycle after acceptance.
REQ-028 WRITE with addr >= IO_BASE and io_buffer_full=1: hold lsb_en=0 and do not advance k until io_buffer_full=0.
REQ-029 When lsb_en=0, drive lsb_wr=0; lsb_addr and lsb_data are don't-care.
REQ-030 Misaligned accesses are legal and are handled byte-serially without exception.
REQ-031 flush_in during READ: drop lsb_en in the next cycle, return to IDLE, suppress resp_valid, discard captured bytes.
REQ-032 flush_in during WRITE or RESP: no effect; the store completes all bytes and responds.
REQ-033 flush_in and req_valid in the same IDLE cycle: no acceptance.
REQ-034 resp_data is 0 on store responses.

Reset
REQ-035 rst_in low immediately forces state=IDLE and sets req_ready, resp_valid, lsb_en, lsb_wr, lsb_addr, lsb_data, resp_data, and byte counters to 0.
REQ-036 rst_in low mid-access abandons the access; partial store bytes already written stay written; no response is issued.
REQ-037 req_ready first rises in the cycle after rst_in deasserts.

Verification
REQ-038 Load word, addr=0x100, memory 0x100..0x103 = 78 56 34 12 -> lsb_addr 0x100..0x103 on consecutive cycles; resp_data=0x12345678 in the 6th cycle after acceptance.
REQ-039 Signed byte load of 0x80 -> resp_data=0xFFFFFF80; unsigned -> 0x00000080; signed half of 0x8001 -> 0xFFFF8001.
REQ-040 Store word 0xDEADBEEF to 0x201 (misaligned) -> writes EF,BE,AD,DE to 0x201..0x204; resp_valid in the 5th cycle after acceptance.
REQ-041 Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> lsb_en stays 0 for 3 cycles, then one write of 0x41; resp_valid follows.
REQ-042 Word load with flush_in in the 2nd issue cycle -> lsb_en low the next cycle, no resp_valid; a new request is accepted afterwards.
REQ-043 rst_in pulsed low during a word store after 2 bytes -> all outputs 0 asynchronously; only 2 bytes written; req_ready=1 the cycle after release.
